dcache_mem_responder: RTL and testbench
=======================================

// Module: dcache_mem_responder
// PURPOSE
//  Memory-side responder for the write-back data cache line interface. It accepts
//  line-allocate (read) and line-write-back (write) requests from the dcache
//  controller and serialises each line into word beats on an internal word RAM.
//  It returns a single-cycle ack, plus the line data on reads.
//  Sits between the dcache controller and the data memory backing store.
// PARAMETERS
//  ADDR_WIDTH   32   byte address width of dcache2mem_addr_i
//  LINE_WIDTH   128  cache line width in bits; must be a multiple of WORD_WIDTH
//  WORD_WIDTH   32   backing RAM word width
//  MEM_WORDS    4096 RAM depth in words; power of 2
//  MEM_LATENCY  2    wait cycles before each beat access (0 allowed)
// PORTS
//  clk_i               in   1           clock, rising edge
//  rst_i               in   1           reset, asynchronous, active-high
//  dcache2mem_req_i    in   1           request; held high until ack, may drop to abort
//  dcache2mem_wr_i     in   1           1 = write-back line, 0 = allocate (read) line
//  dcache2mem_addr_i   in   ADDR_WIDTH  line address; offset bits below the line size ignored
//  dcache2mem_data_i   in   LINE_WIDTH  write-back line data
//  mem2dcache_ack_o    out  1           one-cycle completion pulse
//  mem2dcache_data_o   out  LINE_WIDTH  read line; valid while ack is high, held until next read completes
// BEHAVIOUR
//  - BEATS = LINE_WIDTH/WORD_WIDTH. Beat b uses word address
//    (line_addr*BEATS + b) mod MEM_WORDS, where line_addr = addr >> log2(LINE_WIDTH/8).
//    Beat b maps to line bits [b*WORD_WIDTH +: WORD_WIDTH]; beat 0 is the LSW.
//  - Reset (async, rst_i=1): state IDLE; ack_o=0; data_o=0; beat and wait counters 0.
//    Latched request registers are cleared to 0. RAM contents are not reset.
//    Reset mid-transaction drops the transaction and produces no ack. Beats already
//    written stay written.
//  - FSM states:
//    - IDLE: if req_i=1 at cycle t, latch addr, wr and wdata, then go to BUSY.
//      Otherwise stay in IDLE.
//    - BUSY:
//      - wait_cnt counts 0..MEM_LATENCY.
//      - When wait_cnt==MEM_LATENCY, perform the beat:
//        - write: RAM[word] <= wdata beat.
//        - read: line_buf beat <= RAM[word].
//      - After the beat, clear wait_cnt and increment beat_cnt. After beat BEATS-1, go to ACK.
//      - req_i=0 in any BUSY cycle aborts: go to IDLE next cycle, and the beat in that
//        cycle is not performed.
//    - ACK: ack_o=1 for exactly this cycle. Then go to IDLE; req_i is ignored during ACK.
//      On a read, data_o is updated from line_buf entering ACK.
//  - Latency: a request sampled in IDLE at cycle t gives ack_o=1 at cycle
//    t+1+BEATS*(MEM_LATENCY+1). Defaults: t+13.
//  - Back-to-back: a req high in the cycle after ACK (write-back followed by allocate)
//    is accepted in IDLE with no bubble beyond IDLE.
//  - wr_i, addr_i and data_i are ignored after capture; changing them mid-transaction
//    has no effect.
//  - ack_o is registered (the state-decoded FSM output) and is never high in IDLE or BUSY.
//  - A write never changes data_o.
//  - Counter widths: beat_cnt is $clog2(BEATS) bits, with a minimum of 1.
//    wait_cnt is $clog2(MEM_LATENCY+1) bits, with a minimum of 1.
// STRUCTURE
//  - cache_defs package gets type_dmem_resp_states_e {DMEM_IDLE, DMEM_BUSY, DMEM_ACK}
//    and the DCACHE_LINE_BEATS constant.
//  - Sub-module dmem_word_ram: single-port, WORD_WIDTH x MEM_WORDS, synchronous write,
//    asynchronous read, no reset.
//  - The top level holds the FSM, counters, capture registers, line_buf and data_o.
// TESTING
//  1. Reset: assert rst_i mid-cycle with no clock edge -> ack_o=0 and data_o=0 immediately.
//  2. Write-back then allocate:
//     - wr=1, addr=0x40, data=0x44443333_22221111_DEADBEEF_00C0FFEE; ack at t+13.
//     - Then wr=0, addr=0x40; ack at t'+13 with data_o equal to the written line.
//  3. Back-to-back:
//     - Write-back to 0x80 is followed, in the cycle after its ack, by an allocate of 0x80.
//     - The allocate is accepted with no idle gap, and exactly one ack pulse occurs per request.
//  4. Abort:
//     - Write-back 0x100 of line 0xAAAA...; drop req at t+5 (after beat 0 only).
//     - No ack pulse occurs. A later read of 0x100 returns beat 0 = 0xAAAAAAAA and
//       the other beats with their prior contents.
//  5. Latency sweep: MEM_LATENCY=0 -> ack at t+5; MEM_LATENCY=3 -> ack at t+17.
//  6. Wrap and offset:
//     - Reading addr 0x4F (offset bits set) behaves as a read of 0x40.
//     - A write to addr MEM_WORDS*4+0x40 aliases line 0x40.

Source files
------------

// File: rtl/cache_defs_pkg.sv
// Shared definitions for the dcache memory-side responder: FSM state type,
// default line geometry and a counter-width helper.
package cache_defs;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int DCACHE_WORD_WIDTH = 32;
  localparam int DCACHE_LINE_BEATS = DCACHE_LINE_WIDTH / DCACHE_WORD_WIDTH;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_ACK  = 2'd2
  } type_dmem_resp_states_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_mem_responder_ram.sv
// Backing word store: single port, synchronous write, asynchronous read, no reset.
module dmem_word_ram #(
  parameter int WORD_WIDTH = 32,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0]        wdata_i,
  output logic [WORD_WIDTH-1:0]        rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [MEM_WORDS];

  // Word write on the clock edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache line interface. Each line request is
// split into word beats on the internal RAM, each beat preceded by a fixed
// wait, and completion is signalled by a one-cycle ack.
//
// Handshake: the controller raises req with wr/addr/data and holds req high
// until it sees ack (a single-cycle pulse). Dropping req before ack aborts the
// transfer; no ack follows. Request fields are captured once, at acceptance.
module dcache_mem_responder
  import cache_defs::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int WORD_WIDTH  = 32,
  parameter int MEM_WORDS   = 4096,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
  output logic                  mem2dcache_ack_o,
  output logic [LINE_WIDTH-1:0] mem2dcache_data_o
);

  localparam int BEATS    = LINE_WIDTH / WORD_WIDTH;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam int WADDR_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W   = min1_clog2(BEATS);
  localparam int WAIT_W   = min1_clog2(MEM_LATENCY + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LATENCY);

  type_dmem_resp_states_e state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  ack_q, ack_d;

  logic                  beat_fire;
  logic                  ram_we;
  logic [WADDR_W-1:0]    ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata;
  logic [WORD_WIDTH-1:0] ram_rdata;
  logic [ADDR_WIDTH-1:0] word_full;
  logic                  unused_word_hi;

  // Word address of the current beat; wraps modulo the RAM depth by truncation.
  always_comb begin
    word_full = (addr_q >> OFF_BITS) * ADDR_WIDTH'(BEATS) + ADDR_WIDTH'(beat_q);
    ram_addr  = word_full[WADDR_W-1:0];
    ram_wdata = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) ram_wdata = wdata_q[b*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign unused_word_hi = ^word_full[ADDR_WIDTH-1:WADDR_W];

  // A beat happens only on its last wait cycle and only while req is still held.
  assign beat_fire = (state_q == DMEM_BUSY) && dcache2mem_req_i && (wait_q == LAST_WAIT);
  assign ram_we    = beat_fire && wr_q;

  dmem_word_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Next-state logic: capture, wait/beat sequencing, abort and ack decode.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (dcache2mem_req_i) begin
          wr_d    = dcache2mem_wr_i;
          addr_d  = dcache2mem_addr_i;
          wdata_d = dcache2mem_data_i;
          beat_d  = '0;
          wait_d  = '0;
          state_d = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        if (!dcache2mem_req_i) begin
          beat_d  = '0;
          wait_d  = '0;
          state_d = DMEM_IDLE;
        end else if (wait_q != LAST_WAIT) begin
          wait_d = wait_q + WAIT_W'(1);
        end else begin
          wait_d = '0;
          if (!wr_q) begin
            for (int b = 0; b < BEATS; b++) begin
              if (beat_q == BEAT_W'(b)) line_d[b*WORD_WIDTH +: WORD_WIDTH] = ram_rdata;
            end
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DMEM_ACK;
            ack_d   = 1'b1;
            if (!wr_q) data_d = line_d;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DMEM_ACK: state_d = DMEM_IDLE;
      default:  state_d = DMEM_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DMEM_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
    end
  end

  assign mem2dcache_ack_o  = ack_q;
  assign mem2dcache_data_o = data_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: three instances (latency 2, 0, 3) driven
// from one stimulus process, a line-level memory model per instance, and a
// per-cycle compare of ack and data against the model's expected queue.
module tb_dcache_mem_responder;

  localparam int NDUT  = 3;
  localparam int BEATS = 4;
  localparam int LW    = 128;
  localparam int WW    = 32;
  localparam int MW    = 4096;

  typedef struct {
    int            d;
    int            cyc;
    bit            rd;
    logic [LW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_v   [NDUT];
  logic          wr_v    [NDUT];
  logic [31:0]   addr_v  [NDUT];
  logic [LW-1:0] wdata_v [NDUT];
  logic          ack_v   [NDUT];
  logic [LW-1:0] rdata_v [NDUT];

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  bit            cmp_en = 1'b0;
  int            idle_from [NDUT];
  logic [WW-1:0] mem_m [NDUT][MW];
  logic [LW-1:0] last_data [NDUT];
  exp_t          exp_q[$];

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    dcache_mem_responder #(
      .ADDR_WIDTH  (32),
      .LINE_WIDTH  (LW),
      .WORD_WIDTH  (WW),
      .MEM_WORDS   (MW),
      .MEM_LATENCY ((gi == 0) ? 2 : (gi == 1) ? 0 : 3)
    ) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .dcache2mem_req_i  (req_v[gi]),
      .dcache2mem_wr_i   (wr_v[gi]),
      .dcache2mem_addr_i (addr_v[gi]),
      .dcache2mem_data_i (wdata_v[gi]),
      .mem2dcache_ack_o  (ack_v[gi]),
      .mem2dcache_data_o (rdata_v[gi])
    );
  end

  // ---------------- model helpers ----------------
  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 3;
  endfunction

  // Word index of beat b of the line holding byte address addr.
  function automatic int wa(input logic [31:0] addr, input int b);
    longint la;
    la = longint'(addr / 16);
    return int'((la * BEATS + b) % MW);
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("rst_ack%0d", d), LW'(ack_v[d]), '0);
        chk($sformatf("rst_data%0d", d), rdata_v[d], '0);
      end
    end else if (cmp_en) begin
      for (int d = 0; d < NDUT; d++) begin
        bit   found;
        exp_t e;
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!found && exp_q[i].d == d && exp_q[i].cyc == cyc) begin
            found = 1'b1;
            e = exp_q[i];
            exp_q.delete(i);
          end
        end
        chk($sformatf("ack%0d", d), LW'(ack_v[d]), LW'(found));
        if (found && e.rd) last_data[d] = e.data;
        chk($sformatf("data%0d", d), rdata_v[d], last_data[d]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic scramble(input int d);
    wr_v[d]    = 1'($urandom_range(0, 1));
    addr_v[d]  = $urandom;
    wdata_v[d] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One line request on instance d. abort_k >= 0 drops req in cycle t+abort_k.
  // keep=1 leaves req high after ack so a follow-on request can chain.
  task automatic run_txn(input int d, input bit wr, input logic [31:0] addr,
                         input logic [LW-1:0] wd, input int abort_k, input bit keep,
                         output int t, output int ack_c, output logic [LW-1:0] rd);
    int            lat;
    int            exp_c;
    logic [LW-1:0] line;
    lat   = lat_of(d);
    req_v[d]   = 1'b1;
    wr_v[d]    = wr;
    addr_v[d]  = addr;
    wdata_v[d] = wd;
    t     = (cyc > idle_from[d]) ? cyc : idle_from[d];
    exp_c = t + 1 + BEATS * (lat + 1);
    ack_c = -1;
    rd    = '0;
    if (abort_k >= 0) begin
      while (cyc < t + abort_k) begin
        @(negedge clk);
        if (cyc > t && cyc < t + abort_k) scramble(d);
      end
      req_v[d] = 1'b0;
      if (wr) begin
        for (int b = 0; b < (abort_k - 1) / (lat + 1); b++) mem_m[d][wa(addr, b)] = wd[b*WW +: WW];
      end
      idle_from[d] = cyc + 1;
      while (cyc < exp_c + 2) @(negedge clk);
      return;
    end
    line = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (wr) mem_m[d][wa(addr, b)] = wd[b*WW +: WW];
      else    line[b*WW +: WW] = mem_m[d][wa(addr, b)];
    end
    exp_q.push_back('{d: d, cyc: exp_c, rd: !wr, data: line});
    idle_from[d] = exp_c + 1;
    forever begin
      @(negedge clk);
      if (ack_v[d] === 1'b1) begin
        ack_c = cyc;
        rd    = rdata_v[d];
        break;
      end
      if (cyc > exp_c + 4) begin
        total++;
        bad++;
        $display("FAIL ack_timeout%0d: got=none want=cycle %0d", d, exp_c);
        break;
      end
      if (cyc > t) scramble(d);
    end
    if (!keep) req_v[d] = 1'b0;
  endtask

  task automatic prefill(input int d);
    int t, a;
    logic [LW-1:0] r;
    for (int l = 0; l < 32; l++) begin
      run_txn(d, 1'b1, 32'(l * 16), {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, t, a, r);
    end
  endtask

  task automatic rand_run(input int d, input int n);
    int t, a, k;
    logic [LW-1:0] r;
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      addr = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 31) * 16) | 32'($urandom_range(0, 15));
      k = ($urandom_range(0, 7) == 0) ? $urandom_range(1, BEATS * (lat_of(d) + 1)) : -1;
      run_txn(d, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom, $urandom, $urandom},
              k, 1'($urandom_range(0, 1)), t, a, r);
      if ($urandom_range(0, 3) == 0) begin
        req_v[d] = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_v[d] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t1, a1, t2, a2;
    logic [LW-1:0] r1, r2;
    for (int d = 0; d < NDUT; d++) begin
      req_v[d] = 1'b0; wr_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0;
      idle_from[d] = 0; last_data[d] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    for (int d = 0; d < NDUT; d++) idle_from[d] = cyc;

    // model pins
    chk("wa_offset", LW'(wa(32'h4F, 3)), LW'(19));
    chk("wa_alias",  LW'(wa(32'h4040, 0)), LW'(16));

    fork
      prefill(0);
      prefill(1);
      prefill(2);
    join

    // write-back then allocate
    run_txn(0, 1'b1, 32'h40, 128'h44443333_22221111_DEADBEEF_00C0FFEE, -1, 1'b0, t1, a1, r1);
    chk("wb_latency", LW'(a1 - t1), LW'(13));
    run_txn(0, 1'b0, 32'h40, '0, -1, 1'b0, t2, a2, r2);
    chk("rd_latency", LW'(a2 - t2), LW'(13));
    chk("rd_data", r2, 128'h44443333_22221111_DEADBEEF_00C0FFEE);

    // back-to-back with no idle gap
    run_txn(0, 1'b1, 32'h80, 128'h01234567_89ABCDEF_FEDCBA98_76543210, -1, 1'b1, t1, a1, r1);
    run_txn(0, 1'b0, 32'h80, '0, -1, 1'b0, t2, a2, r2);
    chk("b2b_ack_spacing", LW'(a2 - a1), LW'(14));
    chk("b2b_data", r2, 128'h01234567_89ABCDEF_FEDCBA98_76543210);

    // abort after beat 0
    run_txn(0, 1'b1, 32'h100, 128'h11111111_22222222_33333333_44444444, -1, 1'b0, t1, a1, r1);
    run_txn(0, 1'b1, 32'h100, {4{32'hAAAAAAAA}}, 5, 1'b0, t1, a1, r1);
    run_txn(0, 1'b0, 32'h100, '0, -1, 1'b0, t2, a2, r2);
    chk("abort_data", r2, 128'h11111111_22222222_33333333_AAAAAAAA);

    // latency sweep
    run_txn(1, 1'b1, 32'h40, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, -1, 1'b0, t1, a1, r1);
    chk("lat0_wr", LW'(a1 - t1), LW'(5));
    run_txn(1, 1'b0, 32'h40, '0, -1, 1'b0, t2, a2, r2);
    chk("lat0_rd", LW'(a2 - t2), LW'(5));
    chk("lat0_data", r2, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);
    run_txn(2, 1'b1, 32'h40, 128'hBEEF0003_BEEF0002_BEEF0001_BEEF0000, -1, 1'b0, t1, a1, r1);
    chk("lat3_wr", LW'(a1 - t1), LW'(17));
    run_txn(2, 1'b0, 32'h40, '0, -1, 1'b0, t2, a2, r2);
    chk("lat3_rd", LW'(a2 - t2), LW'(17));
    chk("lat3_data", r2, 128'hBEEF0003_BEEF0002_BEEF0001_BEEF0000);

    // offset bits ignored; high address bits wrap onto the same line
    run_txn(0, 1'b0, 32'h4F, '0, -1, 1'b0, t2, a2, r2);
    chk("offset_rd", r2, 128'h44443333_22221111_DEADBEEF_00C0FFEE);
    run_txn(0, 1'b1, 32'h4040, 128'h0BADF00D_CAFEF00D_12345678_9ABCDEF0, -1, 1'b0, t1, a1, r1);
    run_txn(0, 1'b0, 32'h40, '0, -1, 1'b0, t2, a2, r2);
    chk("alias_rd", r2, 128'h0BADF00D_CAFEF00D_12345678_9ABCDEF0);

    // asynchronous reset in the middle of a read, between clock edges
    @(negedge clk);
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h80;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("async_rst_ack%0d", d), LW'(ack_v[d]), '0);
      chk($sformatf("async_rst_data%0d", d), rdata_v[d], '0);
      last_data[d] = '0;
    end
    exp_q.delete();
    req_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) idle_from[d] = cyc;
    run_txn(0, 1'b0, 32'h40, '0, -1, 1'b0, t2, a2, r2);
    chk("post_rst_rd", r2, 128'h0BADF00D_CAFEF00D_12345678_9ABCDEF0);
    chk("post_rst_lat", LW'(a2 - t2), LW'(13));

    // randomized traffic on all instances concurrently
    fork
      rand_run(0, 60);
      rand_run(1, 60);
      rand_run(2, 60);
    join

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_acks: got=%0d outstanding want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus process wedges.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
